// File: rtl/sample_decoder.sv
// sample_decoder
// Turns one 80-sample window from the 40 kHz shift sampler into a 7-bit
// character. The window holds 8 symbols of 10 samples each: a start symbol
// followed by 7 data symbols, MSB first. Each symbol is resolved by majority
// vote (count of ones against THRESHOLD). One symbol is voted per clock, so
// a full decode takes 8 cycles plus one output cycle.
//
// Optional feature: define SAMPLE_DECODER_ERR_COUNT_EN to add an 8-bit
// saturating err_count output that counts frame_err and overrun pulses.

module sample_decoder #(
  parameter int SAMPLES_PER_SYM = 10,
  parameter int NUM_SYM         = 8,
  parameter int THRESHOLD       = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SYM*SAMPLES_PER_SYM-1:0]   sample,
  input  logic                                 sample_flag,
  output logic [NUM_SYM-2:0]                   data,
  output logic                                 data_valid,
  output logic                                 frame_err,
  output logic                                 overrun,
  output logic                                 busy
`ifdef SAMPLE_DECODER_ERR_COUNT_EN
  ,
  output logic [7:0]                           err_count
`endif
);

  localparam int WIN_W  = NUM_SYM * SAMPLES_PER_SYM;
  localparam int DATA_W = NUM_SYM - 1;
  localparam int IDX_W  = $clog2(NUM_SYM);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VOTE = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]                 state;
  logic                       flag_d;
  logic [WIN_W-1:0]           win;
  logic [IDX_W-1:0]           sym_idx;
  logic                       start_ok;
  logic [DATA_W-1:0]          shreg;

  logic                       window_end;
  logic [SAMPLES_PER_SYM-1:0] cur_slice;
  logic [3:0]                 ones;
  logic                       sym_bit;

  // Counts the ones in one symbol; 4 bits covers the 0..10 range.
  function automatic logic [3:0] popcount(input logic [SAMPLES_PER_SYM-1:0] s);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < SAMPLES_PER_SYM; i++) begin
      c = c + {3'b000, s[i]};
    end
    return c;
  endfunction

  assign window_end = flag_d && !sample_flag;

  // The latched window is shifted left one symbol per vote cycle, so the
  // symbol currently being voted always sits in the top slice.
  assign cur_slice = win[WIN_W-1 -: SAMPLES_PER_SYM];
  assign ones      = popcount(cur_slice);
  assign sym_bit   = (ones >= 4'(THRESHOLD));

  // Control FSM, window latch, per-symbol vote and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flag_d     <= 1'b0;
      win        <= '0;
      sym_idx    <= '0;
      start_ok   <= 1'b0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      flag_d     <= sample_flag;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (window_end) begin
            win     <= sample;
            sym_idx <= '0;
            state   <= VOTE;
            busy    <= 1'b1;
          end
        end
        VOTE: begin
          if (window_end) begin
            overrun <= 1'b1;
          end
          win <= win << SAMPLES_PER_SYM;
          if (sym_idx == '0) begin
            start_ok <= sym_bit;
          end else begin
            shreg <= {shreg[DATA_W-2:0], sym_bit};
          end
          sym_idx <= sym_idx + 1'b1;
          if (sym_idx == IDX_W'(NUM_SYM - 1)) begin
            state <= OUT;
          end
        end
        OUT: begin
          if (window_end) begin
            overrun <= 1'b1;
          end
          if (start_ok) begin
            data       <= shreg;
            data_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAMPLE_DECODER_ERR_COUNT_EN
  logic       fe_next;
  logic       ov_next;
  logic [8:0] err_sum;

  // Error increments are taken from the same conditions that raise the
  // pulses, so the count moves in the same cycle the pulses appear.
  always_comb begin
    fe_next = (state == OUT) && !start_ok;
    ov_next = window_end && (state != IDLE);
    err_sum = {1'b0, err_count} + {8'd0, fe_next} + {8'd0, ov_next};
  end

  // Saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_sum > 9'd255) begin
      err_count <= 8'd255;
    end else begin
      err_count <= err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_sample_decoder.sv
// Testbench for sample_decoder: directed frames from the test plan followed
// by randomized windows, all checked against a behavioural decode model.
// Honours SAMPLE_DECODER_ERR_COUNT_EN when defined for the build.

`timescale 1ns/1ps

module tb_sample_decoder;

  logic        clk;
  logic        rst;
  logic [79:0] sample;
  logic        sample_flag;
  logic [6:0]  data;
  logic        data_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;
`ifdef SAMPLE_DECODER_ERR_COUNT_EN
  logic [7:0]  err_count;
  int          exp_err;
`endif

  int          errors;
  int          checks;
  logic [6:0]  exp_data;

  sample_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .sample_flag (sample_flag),
    .data        (data),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
`ifdef SAMPLE_DECODER_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // 40 kHz in the real system; the period is arbitrary for simulation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build one symbol with exactly cnt ones at random positions.
  function automatic logic [9:0] symBits(input int cnt);
    logic [9:0] s;
    int         n;
    int         pos;
    s = '0;
    n = 0;
    while (n < cnt) begin
      pos = int'($urandom_range(0, 9));
      if (!s[pos]) begin
        s[pos] = 1'b1;
        n++;
      end
    end
    return s;
  endfunction

  // Assemble a window from per-symbol ones counts; symbol 0 is oldest.
  function automatic logic [79:0] makeWindow(input int cnt [8]);
    logic [79:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      w[79 - 10*k -: 10] = symBits(cnt[k]);
    end
    return w;
  endfunction

  // Reference decode: tally ones per symbol, majority against 6.
  task automatic modelDecode(input logic [79:0] w, output logic start_ok, output logic [6:0] ch);
    int cnt [8];
    int value;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int b = 0; b < 80; b++) begin
      cnt[(79 - b) / 10] += int'(w[b]);
    end
    start_ok = (cnt[0] >= 6);
    value = 0;
    for (int k = 1; k < 8; k++) begin
      value = value * 2 + ((cnt[k] >= 6) ? 1 : 0);
    end
    ch = 7'(value);
  endtask

  // Run one window through the decoder. ovAt (2..9, 0 = none) is the edge
  // after E at which a second window end is detected; rstAt (1..8, 0 = none)
  // is the cycle after E at which reset is asserted.
  task automatic applyStimulus(input logic [79:0] w, input int ovAt, input int rstAt, input string tag);
    logic       exp_start;
    logic [6:0] exp_ch;
    logic       aborted;
    modelDecode(w, exp_start, exp_ch);
    aborted = 1'b0;

    sample      = w;
    sample_flag = 1'b1;
    tick();
    sample_flag = 1'b0;
    tick();
    sample = {$urandom(), $urandom(), 16'($urandom())};
    checkOutput({tag, "_busy_at_E"}, busy, 1);
    checkOutput({tag, "_dv_at_E"}, data_valid, 0);

    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (aborted) rst = 1'b0;
      if (ovAt > 0 && cyc == ovAt - 1) sample_flag = 1'b1;
      if (ovAt > 0 && cyc == ovAt) sample_flag = 1'b0;
      tick();

      if (aborted) begin
        checkOutput({tag, "_abort_dv"}, data_valid, 0);
        checkOutput({tag, "_abort_fe"}, frame_err, 0);
        checkOutput({tag, "_abort_busy"}, busy, 0);
        checkOutput({tag, "_abort_data"}, data, exp_data);
        continue;
      end

      if (cyc == 9 && exp_start) exp_data = exp_ch;
      checkOutput({tag, "_ovr"}, overrun, (ovAt > 0 && cyc == ovAt) ? 1 : 0);
      checkOutput({tag, "_data"}, data, exp_data);
      if (cyc <= 8) begin
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_dv_early"}, data_valid, 0);
        checkOutput({tag, "_fe_early"}, frame_err, 0);
      end else if (cyc == 9) begin
        checkOutput({tag, "_dv"}, data_valid, exp_start ? 1 : 0);
        checkOutput({tag, "_fe"}, frame_err, exp_start ? 0 : 1);
      end else begin
        checkOutput({tag, "_dv_late"}, data_valid, 0);
        checkOutput({tag, "_fe_late"}, frame_err, 0);
        checkOutput({tag, "_busy_late"}, busy, 0);
      end

      if (rstAt > 0 && cyc == rstAt) begin
        rst = 1'b1;
        #1;
        aborted  = 1'b1;
        exp_data = '0;
`ifdef SAMPLE_DECODER_ERR_COUNT_EN
        exp_err  = 0;
`endif
        checkOutput({tag, "_rst_busy"}, busy, 0);
        checkOutput({tag, "_rst_data"}, data, 0);
        checkOutput({tag, "_rst_dv"}, data_valid, 0);
        checkOutput({tag, "_rst_ovr"}, overrun, 0);
      end
    end

`ifdef SAMPLE_DECODER_ERR_COUNT_EN
    if (!aborted) begin
      exp_err += (exp_start ? 0 : 1) + (ovAt > 0 ? 1 : 0);
      if (exp_err > 255) exp_err = 255;
    end
    checkOutput({tag, "_errcnt"}, err_count, exp_err);
`endif
  endtask

  initial begin
    int          cnt [8];
    logic [79:0] w;
    int          ov;
    int          ra;

    errors      = 0;
    checks      = 0;
    exp_data    = '0;
`ifdef SAMPLE_DECODER_ERR_COUNT_EN
    exp_err     = 0;
`endif
    rst         = 1'b1;
    sample_flag = 1'b0;
    sample      = '0;
    tick();
    tick();
    checkOutput("reset_data", data, 0);
    checkOutput("reset_dv", data_valid, 0);
    checkOutput("reset_fe", frame_err, 0);
    checkOutput("reset_ovr", overrun, 0);
    checkOutput("reset_busy", busy, 0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("idle_after_reset_busy", busy, 0);

    $display("[TB] clean 'A'");
    cnt = '{10, 10, 0, 0, 0, 0, 0, 10};
    applyStimulus(makeWindow(cnt), 0, 0, "cleanA");
    checkOutput("cleanA_char", data, 7'h41);

    $display("[TB] noisy 'A'");
    cnt = '{7, 7, 3, 3, 3, 3, 3, 7};
    applyStimulus(makeWindow(cnt), 0, 0, "noisyA");
    checkOutput("noisyA_char", data, 7'h41);

    $display("[TB] threshold boundary");
    cnt = '{10, 6, 5, 0, 0, 0, 0, 0};
    applyStimulus(makeWindow(cnt), 0, 0, "thresh");
    checkOutput("thresh_char", data, 7'h40);

    $display("[TB] bad start");
    cnt = '{4, 10, 10, 10, 10, 10, 10, 10};
    applyStimulus(makeWindow(cnt), 0, 0, "badstart");
    checkOutput("badstart_char_held", data, 7'h40);
`ifdef SAMPLE_DECODER_ERR_COUNT_EN
    checkOutput("badstart_errcnt_one", err_count, 1);
`endif

    $display("[TB] overrun during vote");
    cnt = '{10, 10, 0, 0, 0, 0, 0, 10};
    applyStimulus(makeWindow(cnt), 4, 0, "ovr4");
    checkOutput("ovr4_char", data, 7'h41);

    $display("[TB] overrun during output with bad start");
    cnt = '{5, 0, 10, 10, 0, 0, 0, 0};
    applyStimulus(makeWindow(cnt), 9, 0, "ovr9");

    $display("[TB] reset mid-decode");
    cnt = '{10, 0, 10, 10, 10, 0, 0, 10};
    applyStimulus(makeWindow(cnt), 0, 4, "rst4");
    checkOutput("rst4_char", data, 0);

    $display("[TB] randomized windows");
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++) cnt[k] = int'($urandom_range(0, 10));
      w  = makeWindow(cnt);
      ov = 0;
      ra = 0;
      if ($urandom_range(0, 3) == 0) ov = int'($urandom_range(2, 9));
      else if ($urandom_range(0, 7) == 0) ra = int'($urandom_range(1, 8));
      applyStimulus(w, ov, ra, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
